ps2_move_decoder: RTL
=====================

# ps2_move_decoder

PS/2 keyboard receiver and key decoder that produces the held-key `move_up`/`move_down`/`move_right`/`move_left` levels consumed by the player-drawing stage. It sits between the board's PS/2 pins and the rectangle/player renderer in the system clock domain. It deserialises PS/2 device-to-host frames, checks them, and tracks make/break codes for arrow keys and WASD. Each move output stays high exactly while its key is held.

## Interface
- `TIMEOUT`, default 40000: clk cycles without a PS/2 falling edge before a partial frame is discarded.
- `clk` in 1: system clock (40 MHz).
- `rst` in 1: reset `rst`, synchronous, active-high; clock `clk`.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `move_up` out 1: level, high while W or Up-arrow is held.
- `move_down` out 1: level, high while S or Down-arrow is held.
- `move_right` out 1: level, high while D or Right-arrow is held.
- `move_left` out 1: level, high while A or Left-arrow is held.
- `rx_data` out 8: last correctly received byte.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `rx_err` out 1: one-cycle pulse on a parity or stop-bit error.

## Operation
- **Synchroniser:** 2-FF synchronisers on `ps2_clk` and `ps2_data`, plus one history register on the synced clock.
  - `fall` = previous synced clock 1 and current synced clock 0.
  - Data is sampled from the synced data when `fall` is high.
- **Frame format:** start bit 0, 8 data bits LSB first, odd parity, stop bit 1. Each bit is sampled on `fall`.
- **Receiver FSM:**
  - IDLE: on `fall` with data 0, go to DATA with bit count 0. On `fall` with data 1, stay in IDLE (glitch or stray edge).
  - DATA: shift one bit per `fall`. After the 8th bit, go to PARITY.
  - PARITY: store the bit, then go to STOP.
  - STOP: on `fall`, the byte is good if data XOR parity gives odd overall parity and the stop bit is 1.
    - Good byte: pulse `rx_valid` and update `rx_data`.
    - Bad byte: pulse `rx_err`; `rx_data` is unchanged.
    - In both cases return to IDLE.
- **Watchdog:** in any state other than IDLE, a counter increments every cycle and clears on `fall`.
  - When it reaches `TIMEOUT - 1`, the FSM returns to IDLE.
  - No `rx_valid`, no `rx_err`; prefix flags are untouched.
- **Decoder:** acts on each good byte and keeps two flags, `ext` and `brk`.
  - 0xE0 sets `ext`; 0xF0 sets `brk`; no move change for either.
  - With `ext`=1: 0x75 = up, 0x72 = down, 0x74 = right, 0x6B = left.
  - With `ext`=0: 0x1D = up, 0x1B = down, 0x23 = right, 0x1C = left.
  - On a matching key: the mapped move output is set to `!brk`.
  - Any byte other than 0xE0/0xF0 clears both `ext` and `brk`. This applies to matched and unmatched codes alike.
  - `rx_err` also clears both flags.
- **Independent outputs:** keys never affect each other. W and Up both drive `move_up` with last-event-wins semantics. Opposite directions may both be high; the consumer applies priority.
- **Reset values:** FSM IDLE; counters 0; `ext`=`brk`=0; all move outputs 0; `rx_data`=0x00; `rx_valid`=`rx_err`=0; synchroniser stages reset to 1.

## Timing
- Let N be the clk edge at which the first synchroniser stage captures the falling `ps2_clk` of the stop bit.
- `fall` is high during cycle N+2.
- `rx_valid`/`rx_err` and `rx_data` are registered at edge N+3.
- Move outputs update at edge N+4.
- `rx_valid` and `rx_err` are single-cycle pulses and are never high together.
- Reset mid-frame: the next cycle is fully in reset state; the partial frame is lost and no pulse is issued.
- Data setup: PS/2 data is stable around the clock falling edge and both pins share equal synchroniser depth, so sampled data aligns with `fall`.
- Throughput: one byte per frame (at least 11 PS/2 clocks). No backpressure.

## Test plan
- **W press:** frame 0x1D (parity 1) → `rx_data`=0x1D and a 1-cycle `rx_valid` at N+3; `move_up`=1 at N+4; other moves 0.
- **W release:** frames 0xF0 then 0x1D → `move_up` stays 1 after 0xF0 and drops to 0 at N+4 of the 0x1D frame.
- **Left arrow:** 0xE0, 0x6B → `move_left`=1. A bare 0x6B afterwards changes nothing. Then 0xE0, 0xF0, 0x6B → `move_left`=0.
- **Parity error:** frame 0x23 with parity bit 1 (wrong) → `rx_err` pulse, no `rx_valid`, `move_right` stays 0, `rx_data` keeps its previous value.
- **Parity error clears prefix:** 0xE0, then a bad-parity frame, then 0x75 → no change to `move_up`.
- **Timeout:** start bit plus 4 data bits, then idle for `TIMEOUT`+10 cycles, then a full 0x23 frame → `move_right`=1, no `rx_err`.
- **Reset mid-frame:** assert `rst` for 1 cycle after 6 bits while `move_down`=1 → all outputs 0. A following full 0x1B frame → `move_down`=1.

Source files
------------

// File: rtl/ps2_move_decoder.sv
// PS/2 device-to-host receiver with arrow/WASD make-break decoding into held-key move levels.
// Bytes are checked for odd parity and stop bit; a watchdog drops stalled partial frames.
module ps2_move_decoder #(
    parameter int TIMEOUT = 40000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       move_up,
    output logic       move_down,
    output logic       move_right,
    output logic       move_left,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WDOG_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Returns {hit, index}; index 0=up, 1=down, 2=right, 3=left.
    function automatic logic [2:0] key_lookup(input logic [7:0] code, input logic ext);
        logic [2:0] res;
        res = 3'b000;
        if (ext) begin
            case (code)
                8'h75:   res = 3'b100;
                8'h72:   res = 3'b101;
                8'h74:   res = 3'b110;
                8'h6B:   res = 3'b111;
                default: res = 3'b000;
            endcase
        end else begin
            case (code)
                8'h1D:   res = 3'b100;
                8'h1B:   res = 3'b101;
                8'h23:   res = 3'b110;
                8'h1C:   res = 3'b111;
                default: res = 3'b000;
            endcase
        end
        return res;
    endfunction

    logic             r_clk_s1, r_clk_s2, r_clk_hist;
    logic             r_dat_s1, r_dat_s2;
    logic             r_fall, r_bit;
    logic             w_fall;
    state_t           r_state, w_next;
    logic [2:0]       r_cnt;
    logic [7:0]       r_shift;
    logic             r_parity;
    logic [CNT_W-1:0] r_wdog;
    logic             w_timeout, w_good, w_bad;
    logic             r_ext, r_brk;
    logic [3:0]       r_move;
    logic [2:0]       w_key;

    assign w_fall = r_clk_hist & ~r_clk_s2;

    // Stage: synchronise pins, then register the falling-edge strobe together with its data bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_hist <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_fall     <= 1'b0;
            r_bit      <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_hist <= r_clk_s2;
            r_dat_s1   <= ps2_data;
            r_dat_s2   <= r_dat_s1;
            r_fall     <= w_fall;
            r_bit      <= r_dat_s2;
        end
    end

    assign w_timeout = (r_state != S_IDLE) && (r_wdog == WDOG_MAX);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (r_fall && !r_bit)          w_next = S_DATA;
            S_DATA:   if (r_fall && r_cnt == 3'd7)   w_next = S_PARITY;
            S_PARITY: if (r_fall)                    w_next = S_STOP;
            S_STOP:   if (r_fall)                    w_next = S_IDLE;
            default:                                 w_next = S_IDLE;
        endcase
        if (!r_fall && w_timeout) w_next = S_IDLE;
    end

    always_comb begin
        w_good = 1'b0;
        w_bad  = 1'b0;
        if (r_state == S_STOP && r_fall) begin
            if (r_bit && (^{r_shift, r_parity})) w_good = 1'b1;
            else                                 w_bad  = 1'b1;
        end
    end

    // Stage: frame datapath, watchdog and received-byte outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 3'd0;
            r_shift  <= 8'h00;
            r_parity <= 1'b0;
            r_wdog   <= '0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            if (r_state == S_IDLE || r_fall) r_wdog <= '0;
            else                             r_wdog <= r_wdog + 1'b1;
            if (r_fall) begin
                if (r_state == S_IDLE) r_cnt <= 3'd0;
                if (r_state == S_DATA) begin
                    r_shift <= {r_bit, r_shift[7:1]};
                    r_cnt   <= r_cnt + 3'd1;
                end
                if (r_state == S_PARITY) r_parity <= r_bit;
            end
            rx_valid <= w_good;
            rx_err   <= w_bad;
            if (w_good) rx_data <= r_shift;
        end
    end

    assign w_key = key_lookup(rx_data, r_ext);

    // Stage: make/break decoder driven by the registered byte pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_move <= 4'b0000;
        end else if (rx_err) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (rx_valid) begin
            if (rx_data == 8'hE0) begin
                r_ext <= 1'b1;
            end else if (rx_data == 8'hF0) begin
                r_brk <= 1'b1;
            end else begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
                if (w_key[2]) r_move[w_key[1:0]] <= ~r_brk;
            end
        end
    end

    assign move_up    = r_move[0];
    assign move_down  = r_move[1];
    assign move_right = r_move[2];
    assign move_left  = r_move[3];
endmodule
